// File: rtl/bus_switch_pkg.sv
// Shared types for the N-to-1 CPU bus switch.
// FSM state encoding and port-index width helper.
package bus_switch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY
   } state_t;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_switch_rr_arbiter.sv
// Round-robin arbiter: rotate past the last grant,
// then take the first set request bit.
module rr_arbiter
   import bus_switch_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IW        = 1
) (
   input  logic [NUM_PORTS-1:0] request,
   input  logic [IW-1:0]        last_grant,
   output logic                 valid,
   output logic [IW-1:0]        next_grant
);

   logic [IW-1:0] cand;

   // Scan from furthest to nearest so the nearest hit wins.
   always_comb begin
      valid      = 1'b0;
      next_grant = '0;
      cand       = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NUM_PORTS);
         if (request[cand]) begin
            valid      = 1'b1;
            next_grant = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_switch.sv
// N-to-1 CPU bus switch with round-robin arbitration,
// transaction locking and an optional watchdog.
module bus_arbiter_switch
   import bus_switch_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    address_m,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    data_out_m,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]    data_in_m,
   input  logic [NUM_PORTS-1:0]               write_enable_m,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  write_mask_m,
   input  logic [NUM_PORTS-1:0]               transaction_begin_m,
   output logic [NUM_PORTS-1:0]               transaction_end_m,
   output logic [ADDR_WIDTH-1:0]              address_y,
   output logic [DATA_WIDTH-1:0]              data_out_y,
   input  logic [DATA_WIDTH-1:0]              data_in_y,
   output logic                               write_enable_y,
   output logic [DATA_WIDTH/8-1:0]            write_mask_y,
   output logic                               transaction_begin_y,
   input  logic                               transaction_end_y,
   output logic [idx_width(NUM_PORTS)-1:0]    grant,
   output logic                               busy,
   output logic                               timeout_error
);

   localparam int IW = idx_width(NUM_PORTS);
   localparam int MW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1
                     : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IW-1:0] GRANT_RST = IW'(NUM_PORTS - 1);

   state_t               state_q, state_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [NUM_PORTS-1:0] pending_q, pending_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 arb_valid;
   logic [IW-1:0]        arb_next;
   logic                 end_fire;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IW        (IW)
   ) u_arb (
      .request    (pending_q),
      .last_grant (grant_q),
      .valid      (arb_valid),
      .next_grant (arb_next)
   );

   // Next-state, grant latch, watchdog counter and strobes.
   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      count_d             = count_q;
      end_fire            = 1'b0;
      transaction_begin_y = 1'b0;
      busy                = 1'b0;
      timeout_error       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_next;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            transaction_begin_y = 1'b1;
            busy                = 1'b1;
            count_d             = '0;
            state_d             = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (transaction_end_y) begin
               end_fire = 1'b1;
               state_d  = IDLE;
            end else if (TIMEOUT_CYCLES > 0 &&
                         count_q == CNT_LAST) begin
               end_fire      = 1'b1;
               timeout_error = 1'b1;
               state_d       = IDLE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // End pulse goes only to the port holding the bus;
   // an end clears pending even if it re-begins this cycle.
   always_comb begin
      transaction_end_m = '0;
      if (end_fire) transaction_end_m[grant_q] = 1'b1;
      pending_d = (pending_q | transaction_begin_m)
                & ~transaction_end_m;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= GRANT_RST;
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   // Slave-side mux follows the registered grant.
   always_comb begin
      address_y      = address_m[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
      data_out_y     = data_out_m[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      write_enable_y = write_enable_m[grant_q];
      write_mask_y   = write_mask_m[int'(grant_q)*MW +: MW];
   end

   assign data_in_m = {NUM_PORTS{data_in_y}};
   assign grant     = grant_q;

endmodule

// File: tb/tb_bus_arbiter_switch.sv
// Scoreboard bench for bus_arbiter_switch: stimulus queues
// expected slave begins and master ends, a monitor checks them.
module tb_bus_arbiter_switch;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;
   localparam int TO = 8;

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  mask;
      int          cyc;
   } beg_t;

   typedef struct {
      int          port;
      logic        to;
      logic [31:0] rdata;
      int          cyc;
   } end_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*AW-1:0] address_m;
   logic [N*DW-1:0] data_out_m;
   logic [N*DW-1:0] data_in_m;
   logic [N-1:0]    write_enable_m;
   logic [N*MW-1:0] write_mask_m;
   logic [N-1:0]    begin_m;
   logic [N-1:0]    end_m;
   logic [AW-1:0]   address_y;
   logic [DW-1:0]   data_out_y;
   logic [DW-1:0]   data_in_y;
   logic            we_y;
   logic [MW-1:0]   mask_y;
   logic            begin_y;
   logic            end_y;
   logic [1:0]      grant;
   logic            busy;
   logic            timeout_error;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   beg_t exp_beg[$];
   end_t exp_end[$];

   logic [31:0] pa[N];
   logic [31:0] pd[N];
   logic        pw[N];
   logic [3:0]  pm[N];

   bus_arbiter_switch #(
      .NUM_PORTS      (N),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .address_m           (address_m),
      .data_out_m          (data_out_m),
      .data_in_m           (data_in_m),
      .write_enable_m      (write_enable_m),
      .write_mask_m        (write_mask_m),
      .transaction_begin_m (begin_m),
      .transaction_end_m   (end_m),
      .address_y           (address_y),
      .data_out_y          (data_out_y),
      .data_in_y           (data_in_y),
      .write_enable_y      (we_y),
      .write_mask_y        (mask_y),
      .transaction_begin_y (begin_y),
      .transaction_end_y   (end_y),
      .grant               (grant),
      .busy                (busy),
      .timeout_error       (timeout_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @cyc %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_port(input int p, input logic [31:0] a,
                           input logic [31:0] d, input logic w,
                           input logic [3:0] m);
      pa[p] = a;
      pd[p] = d;
      pw[p] = w;
      pm[p] = m;
      address_m[p*AW +: AW]  = a;
      data_out_m[p*DW +: DW] = d;
      write_enable_m[p]      = w;
      write_mask_m[p*MW +: MW] = m;
   endtask

   task automatic push_beg(input int p, input int c);
      beg_t b;
      b.port  = p;
      b.addr  = pa[p];
      b.wdata = pd[p];
      b.we    = pw[p];
      b.mask  = pm[p];
      b.cyc   = c;
      exp_beg.push_back(b);
   endtask

   task automatic push_end(input int p, input logic t,
                           input logic [31:0] r, input int c);
      end_t e;
      e.port  = p;
      e.to    = t;
      e.rdata = r;
      e.cyc   = c;
      exp_end.push_back(e);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      begin_m = '0;
      end_y   = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   // Monitor: every slave begin and master end must match
   // the head of its expectation queue.
   always @(negedge clk) begin
      beg_t b;
      end_t e;
      if (begin_y) begin
         if (exp_beg.size() == 0) begin
            chk("unexpected_begin_y", begin_y, 0);
         end else begin
            b = exp_beg.pop_front();
            chk("begin_cycle", cyc, b.cyc);
            chk("begin_grant", grant, b.port);
            chk("address_y", address_y, b.addr);
            chk("data_out_y", data_out_y, b.wdata);
            chk("write_enable_y", we_y, b.we);
            chk("write_mask_y", mask_y, b.mask);
         end
      end
      if (end_m != '0) begin
         if (exp_end.size() == 0) begin
            chk("unexpected_end_m", end_m, 0);
         end else begin
            e = exp_end.pop_front();
            chk("end_cycle", cyc, e.cyc);
            chk("end_m", end_m, 32'(1) << e.port);
            chk("end_grant", grant, e.port);
            chk("timeout_error", timeout_error, e.to);
            chk("data_in_m", data_in_m[e.port*DW +: DW], e.rdata);
         end
      end else if (timeout_error) begin
         chk("stray_timeout", timeout_error, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      address_m      = '0;
      data_out_m     = '0;
      write_enable_m = '0;
      write_mask_m   = '0;
      data_in_y      = '0;
      for (int p = 0; p < N; p++) set_port(p, 0, 0, 0, 0);

      // Reset state
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_begin_y", begin_y, 0);
      chk("rst_end_m", end_m, 0);
      chk("rst_timeout", timeout_error, 0);
      chk("rst_grant", grant, N - 1);

      // Single write on port 1
      set_port(1, 32'h1000, 32'hDEADBEEF, 1'b1, 4'hF);
      t = cyc;
      begin_m = 4'b0010;
      push_beg(1, t + 2);
      step();
      begin_m = '0;
      step(4);
      data_in_y = 32'hCAFE0001;
      end_y     = 1'b1;
      push_end(1, 1'b0, 32'hCAFE0001, t + 5);
      step();
      end_y = 1'b0;
      step(3);

      // Two simultaneous begins, then a read
      do_reset();
      set_port(0, 32'h2000, 32'h11111111, 1'b1, 4'h3);
      set_port(1, 32'h3000, 32'h22222222, 1'b0, 4'h0);
      t = cyc;
      begin_m = 4'b0011;
      push_beg(0, t + 2);
      push_beg(1, t + 6);
      step();
      begin_m = '0;
      step(3);
      data_in_y = 32'hAAAA5555;
      end_y     = 1'b1;
      push_end(0, 1'b0, 32'hAAAA5555, t + 4);
      step();
      end_y = 1'b0;
      step(3);
      data_in_y = 32'h12345678;
      end_y     = 1'b1;
      push_end(1, 1'b0, 32'h12345678, t + 8);
      step();
      end_y = 1'b0;
      step(2);

      // Fairness: all four ports keep requesting
      do_reset();
      for (int p = 0; p < N; p++)
         set_port(p, 32'h4000 + 32'(p) * 32'h10,
                  32'hA0 + 32'(p), p[0], 4'(1 << p));
      t = cyc;
      for (int k = 0; k < 8; k++) begin
         push_beg(k % N, t + 2 + 4 * k);
         push_end(k % N, 1'b0, 32'h5000 + 32'(k), t + 4 + 4 * k);
      end
      for (int o = 0; o < 36; o++) begin
         begin_m = '0;
         end_y   = 1'b0;
         if (o == 0) begin_m = '1;
         if (o >= 5 && (o - 5) % 4 == 0 && (o - 5) / 4 < N)
            begin_m[(o - 5) / 4] = 1'b1;
         if (o >= 4 && (o - 4) % 4 == 0 && (o - 4) / 4 < 8) begin
            end_y     = 1'b1;
            data_in_y = 32'h5000 + 32'((o - 4) / 4);
         end
         step();
      end
      begin_m = '0;
      end_y   = 1'b0;

      // Watchdog: slave never ends
      do_reset();
      data_in_y = '0;
      set_port(2, 32'h6000, 32'h66666666, 1'b1, 4'hC);
      t = cyc;
      begin_m = 4'b0100;
      push_beg(2, t + 2);
      push_end(2, 1'b1, 32'h0, t + 10);
      step();
      begin_m = '0;
      step(10);
      chk("idle_after_timeout_busy", busy, 0);
      chk("idle_after_timeout_begin", begin_y, 0);

      // Reset while busy with port 2 queued
      do_reset();
      set_port(1, 32'h7000, 32'h77777777, 1'b0, 4'h1);
      set_port(2, 32'h8000, 32'h88888888, 1'b1, 4'h2);
      t = cyc;
      begin_m = 4'b0010;
      push_beg(1, t + 2);
      step();
      begin_m = '0;
      step(2);
      chk("busy_before_reset", busy, 1);
      begin_m = 4'b0100;
      step();
      begin_m = '0;
      reset   = 1'b1;
      step();
      reset = 1'b0;
      chk("busy_after_reset", busy, 0);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("quiet_after_reset", {busy, begin_y, end_m}, 0);
      end

      step(3);
      chk("beg_queue_empty", exp_beg.size(), 0);
      chk("end_queue_empty", exp_end.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
